// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the 32-bit to 16-bit SRAM bridge.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;

  // Byte address that lands on SRAM halfword 0.
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

  // Halfword address of the low half of the word at a byte address.
  // The subtraction wraps at 32 bits; byte-lane bits [1:0] drop out.
  function automatic logic [SRAM_AW-1:0] hw_of(input logic [31:0] address,
                                               input logic [31:0] base);
    return {17'((address - base) >> 2), 1'b0};
  endfunction

endpackage

// File: rtl/sram_ctrl_rd_buf.sv
// sram_ctrl_rd_buf: one-word read buffer (valid flag, halfword tag, data) with tag compare.
// Only instantiated when SRAM_CTRL_RD_BUF_EN is defined.
module sram_ctrl_rd_buf
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fill,
  input  logic [SRAM_AW-1:0] fill_tag,
  input  logic [31:0]        fill_data,
  input  logic               clear,
  input  logic [SRAM_AW-1:0] lookup_tag,
  output logic               hit,
  output logic [31:0]        data
);

  logic               valid_q;
  logic [SRAM_AW-1:0] tag_q;
  logic [31:0]        data_q;

  // Fill on every completed SRAM read; an accepted write invalidates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      data_q  <= fill_data;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign data = data_q;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges 32-bit MEM-stage loads/stores to a 16-bit asynchronous SRAM.
// Each word access is two halfword phases (low half, then high half), each held
// WAIT_CYCLES cycles, followed by one DONE cycle; ready stays low until DONE.
// Optional one-word read buffer: define SRAM_CTRL_RD_BUF_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_address,
  output logic               sram_we_n,
  inout  wire  [SRAM_DW-1:0] sram_dq
);

  localparam logic [2:0] LastCnt = 3'(WAIT_CYCLES - 1);

  state_e             state_q;
  logic [2:0]         cnt_q;
  logic               is_wr_q;
  logic [SRAM_AW-1:0] hw_q;
  logic [SRAM_DW-1:0] wdata_hi_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-1:0] sram_address_q;
  logic               we_n_q;
  logic               dq_oe_q;
  logic [SRAM_DW-1:0] dq_out_q;

  logic               req;
  logic               phase_last;
  logic               buf_hit;
  logic [SRAM_AW-1:0] req_hw;

  assign req        = wr_en | rd_en;
  assign req_hw     = hw_of(address, BASE_ADDR);
  // Counter only advances while below the last value, so it saturates there.
  assign phase_last = (cnt_q == LastCnt);

  // Access sequencer; all SRAM-side outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      is_wr_q        <= 1'b0;
      hw_q           <= '0;
      wdata_hi_q     <= '0;
      read_data_q    <= '0;
      sram_address_q <= '0;
      we_n_q         <= 1'b1;
      dq_oe_q        <= 1'b0;
      dq_out_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && !buf_hit) begin
            // wr_en wins when both requests are present.
            is_wr_q        <= wr_en;
            hw_q           <= req_hw;
            wdata_hi_q     <= write_data[31:16];
            cnt_q          <= '0;
            sram_address_q <= req_hw;
            we_n_q         <= ~wr_en;
            dq_oe_q        <= wr_en;
            dq_out_q       <= write_data[15:0];
            state_q        <= StLow;
          end
        end
        StLow: begin
          if (phase_last) begin
            if (!is_wr_q) read_data_q[15:0] <= sram_dq;
            cnt_q          <= '0;
            sram_address_q <= {hw_q[SRAM_AW-1:1], 1'b1};
            dq_out_q       <= wdata_hi_q;
            state_q        <= StHigh;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StHigh: begin
          if (phase_last) begin
            if (!is_wr_q) read_data_q[31:16] <= sram_dq;
            cnt_q   <= '0;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef SRAM_CTRL_RD_BUF_EN
  logic        buf_match;
  logic        buf_fill;
  logic        buf_clear;
  logic [31:0] buf_data;

  assign buf_fill  = (state_q == StHigh) && phase_last && !is_wr_q;
  assign buf_clear = (state_q == StIdle) && wr_en;

  sram_ctrl_rd_buf u_rd_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (buf_fill),
    .fill_tag   (hw_q),
    .fill_data  ({sram_dq, read_data_q[15:0]}),
    .clear      (buf_clear),
    .lookup_tag (req_hw),
    .hit        (buf_match),
    .data       (buf_data)
  );

  // A hit is served from the buffer in IDLE without touching the SRAM.
  assign buf_hit   = (state_q == StIdle) && rd_en && !wr_en && buf_match;
  assign read_data = buf_hit ? buf_data : read_data_q;
`else
  assign buf_hit   = 1'b0;
  assign read_data = read_data_q;
`endif

  assign ready        = ((state_q == StIdle) && (!req || buf_hit)) || (state_q == StDone);
  assign sram_address = sram_address_q;
  assign sram_we_n    = we_n_q;
  assign sram_dq      = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed plus randomized bench for sram_ctrl against a word-level model
// and an asynchronous SRAM model.
module tb_sram_ctrl;

  localparam logic [31:0] BASE    = 32'd1024;
  localparam int          W       = 1;
  localparam int          DoneCyc = 2 * W + 1;
`ifdef SRAM_CTRL_RD_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_address;
  logic        sram_we_n;
  wire  [15:0] sram_dq;

  sram_ctrl #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_we_n    (sram_we_n),
    .sram_dq      (sram_dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: drives data whenever not being written, stores on clock while we_n low.
  logic [15:0] mem [0:262143];
  bit          mem_init;
  assign sram_dq = sram_we_n ? mem[sram_address] : 16'bz;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 262144; i++) mem[i] <= '0;
    end else if (!sram_we_n) begin
      mem[sram_address] <= sram_dq;
    end
  end

  // Word-level reference model.
  logic [31:0] mw [0:131071];
  logic [31:0] last_read;
  bit          buf_valid;
  logic [17:0] buf_tag;

  // Current-transaction context shared with the compare process.
  bit          active;
  bit          chk_en;
  bit          cur_wr;
  bit          cur_hit;
  int          cur_cyc;
  logic [17:0] cur_hw;
  logic [31:0] cur_wd;
  logic [31:0] cmp_word;
  bit          cmp_lo;

  int n_checks;
  int n_pass;

  function automatic logic [17:0] model_hw(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[18:1] & 18'h3FFFE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Compare process: checks every cycle outside reset against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (!active) begin
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("idle_read_data", read_data, last_read);
      end else begin
        cmp_word = mw[cur_hw[17:1]];
        chk("ready", 32'(ready), 32'(cur_hit || (cur_cyc == DoneCyc)));
        chk("we_n", 32'(sram_we_n), 32'(!(cur_wr && cur_cyc >= 1 && cur_cyc <= 2 * W)));
        if (!cur_hit && cur_cyc >= 1 && cur_cyc <= 2 * W) begin
          cmp_lo = (cur_cyc <= W);
          chk("sram_address", 32'(sram_address), 32'(cmp_lo ? cur_hw : (cur_hw | 18'd1)));
          if (cur_wr) chk("dq_write", 32'(sram_dq), 32'(cmp_lo ? cur_wd[15:0] : cur_wd[31:16]));
          else chk("dq_read", 32'(sram_dq), 32'(cmp_lo ? cmp_word[15:0] : cmp_word[31:16]));
        end
        if (!cur_wr && (cur_hit || cur_cyc == DoneCyc)) chk("read_data", read_data, cmp_word);
        else if (cur_wr || cur_cyc <= W) chk("read_data_hold", read_data, last_read);
      end
    end
  end

  task automatic idle(input int n);
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    active = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One access from request to the cycle after completion; the caller may start
  // the next access immediately (back-to-back) or go idle.
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble);
    logic [17:0] hw;
    bit          hit;
    int          len;
    hw  = model_hw(a);
    hit = BUF && r && !w && buf_valid && (buf_tag == hw);
    wr_en = w;
    rd_en = r;
    address = a;
    write_data = d;
    cur_wr = w;
    cur_hw = hw;
    cur_wd = d;
    cur_hit = hit;
    cur_cyc = 0;
    active = 1'b1;
    if (w) buf_valid = 1'b0;
    len = hit ? 1 : DoneCyc + 1;
    for (int k = 1; k < len; k++) begin
      @(posedge clk);
      #1;
      cur_cyc = k;
      if (scramble && k <= 2 * W) begin
        address    = $urandom;
        write_data = $urandom;
      end else begin
        address    = a;
        write_data = d;
      end
    end
    @(posedge clk);
    #1;
    if (w) begin
      mw[hw[17:1]] = d;
    end else begin
      last_read = mw[hw[17:1]];
      if (!hit) begin
        buf_valid = 1'b1;
        buf_tag   = hw;
      end
    end
  endtask

  logic [31:0] ra;
  logic [31:0] rd;
  int          sel;
  int          gap;

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    address = '0;
    write_data = '0;
    active = 1'b0;
    chk_en = 1'b0;
    last_read = '0;
    buf_valid = 1'b0;
    buf_tag = '0;
    mem_init = 1'b1;
    for (int i = 0; i < 131072; i++) mw[i] = '0;
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_sram_address", 32'(sram_address), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Directed: basic write then reads.
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    idle(1);
    chk("mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("mem1", 32'(mem[1]), 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    idle(1);
    chk("read_1024", read_data, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    idle(2);

    // Back-to-back write then read.
    access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    idle(1);
    chk("mem2", 32'(mem[2]), 32'h00005678);
    chk("mem3", 32'(mem[3]), 32'h00001234);
    chk("read_1028", read_data, 32'h12345678);

    // Both requests: treated as a write.
    access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b0);
    idle(1);
    chk("mem4", 32'(mem[4]), 32'h00005A5A);
    chk("mem5", 32'(mem[5]), 32'h0000A5A5);
    chk("read_hold_after_write", read_data, 32'h12345678);

    // Randomized traffic in a small window plus wrapped addresses below BASE.
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) ra = BASE - 32'(4 * $urandom_range(1, 4));
      else ra = BASE + 32'(4 * $urandom_range(0, 15));
      ra = ra | 32'($urandom_range(0, 3));
      rd = $urandom;
      access(sel <= 4, sel >= 4, ra, rd, $urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(1);

    // Reset during the HIGH phase of a write.
    wr_en = 1'b1;
    rd_en = 1'b0;
    address = BASE + 32'd76;
    write_data = 32'h0BADF00D;
    cur_wr = 1'b1;
    cur_hw = model_hw(address);
    cur_wd = write_data;
    cur_hit = 1'b0;
    cur_cyc = 0;
    active = 1'b1;
    buf_valid = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk);
      #1;
      cur_cyc = k;
    end
    #2;
    chk("abort_we_n_before", 32'(sram_we_n), 32'd0);
    active = 1'b0;
    chk_en = 1'b0;
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_sram_address", 32'(sram_address), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    last_read = '0;
    buf_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
